// File: rtl/tx_link_pkg.sv
// Shared encodings for the JESD204B transmit link controller: FSM states,
// link-layer stream select codes and counter widths.
package tx_link_pkg;

  localparam logic [1:0] ST_CGS  = 2'd0;
  localparam logic [1:0] ST_ILA  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [2:0] MUX_USER = 3'd0;
  localparam logic [2:0] MUX_K    = 3'd1;
  localparam logic [2:0] MUX_ILA  = 3'd2;

  // F*K <= 1024 and F <= 256 bound these widths.
  localparam int CNT_W = 10;
  localparam int FRM_W = 8;

  function automatic logic [2:0] muxOf(input logic [1:0] state);
    case (state)
      ST_ILA:  muxOf = MUX_ILA;
      ST_DATA: muxOf = MUX_USER;
      default: muxOf = MUX_K;
    endcase
  endfunction

endpackage

// File: rtl/lmfc_counter.sv
// Free-running LMFC octet counter (0..F*K-1) and octet-in-frame index
// (0..F-1); only rst_n restarts them.
module lmfc_counter
  import tx_link_pkg::*;
#(
  parameter int F = 2,
  parameter int K = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] o_count,
  output logic [FRM_W-1:0] o_frame_idx,
  output logic             o_lmfc,
  output logic             o_frame_start
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(F * K - 1);
  localparam logic [FRM_W-1:0] LAST_FRM = FRM_W'(F - 1);

  logic [CNT_W-1:0] r_count;
  logic [FRM_W-1:0] r_frame;
  logic             r_lmfc;
  logic             r_frameStart;
  logic [CNT_W-1:0] w_countNext;
  logic [FRM_W-1:0] w_frameNext;

  always_comb begin
    w_countNext = (r_count == LAST_CNT) ? '0 : r_count + CNT_W'(1);
    w_frameNext = (r_frame == LAST_FRM) ? '0 : r_frame + FRM_W'(1);
  end

  // Flags are registered from the next count so they line up with the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count      <= '0;
      r_frame      <= '0;
      r_lmfc       <= 1'b1;
      r_frameStart <= 1'b1;
    end else begin
      r_count      <= w_countNext;
      r_frame      <= w_frameNext;
      r_lmfc       <= (w_countNext == '0);
      r_frameStart <= (w_frameNext == '0);
    end
  end

  assign o_count       = r_count;
  assign o_frame_idx   = r_frame;
  assign o_lmfc        = r_lmfc;
  assign o_frame_start = r_frameStart;

endmodule

// File: rtl/tx_link_ctrl.sv
// JESD204B transmit link controller: CGS -> ILA (4 multiframes) -> DATA,
// with SYNC~ low-run tracking for resync and short-pulse error reports.
module tx_link_ctrl
  import tx_link_pkg::*;
#(
  parameter int F          = 2,
  parameter int K          = 16,
  parameter int RESYNC_CYC = 5 * F + 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sync_n,
  output logic [2:0] o_link_mux,
  output logic [1:0] o_state,
  output logic       o_lmfc,
  output logic       o_frame_start,
  output logic [1:0] o_ila_mf,
  output logic       o_sync_err
);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(F * K - 1);
  localparam logic [FRM_W-1:0] LAST_FRM  = FRM_W'(F - 1);
  localparam logic [7:0]       RESYNC_LV = 8'(RESYNC_CYC);

  logic [CNT_W-1:0] w_count;
  logic [FRM_W-1:0] w_frameIdx;

  logic [1:0] r_state;
  logic [1:0] r_ilaMf;
  logic [7:0] r_lowRun;
  logic [2:0] r_mux;
  logic       r_syncErr;

  logic [1:0] w_nextState;
  logic [1:0] w_nextMf;
  logic [7:0] w_lowNext;
  logic       w_boundary;
  logic       w_resync;
  logic       w_errNext;

  lmfc_counter #(
    .F(F),
    .K(K)
  ) u_lmfc (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_count      (w_count),
    .o_frame_idx  (w_frameIdx),
    .o_lmfc       (o_lmfc),
    .o_frame_start(o_frame_start)
  );

  // The last LMFC octet is always also the last octet of a frame.
  always_comb begin
    w_lowNext  = i_sync_n ? 8'd0 : ((r_lowRun == 8'hFF) ? 8'hFF : r_lowRun + 8'd1);
    w_boundary = (w_count == LAST_CNT) && (w_frameIdx == LAST_FRM);
    w_resync   = (r_state != ST_CGS) && (w_lowNext == RESYNC_LV);
    w_errNext  = (r_state == ST_DATA) && i_sync_n && (r_lowRun != 8'd0) &&
                 (r_lowRun < RESYNC_LV);
  end

  // Resync outranks the ILA-end boundary when both land on one edge.
  always_comb begin
    w_nextState = r_state;
    w_nextMf    = r_ilaMf;
    case (r_state)
      ST_CGS: begin
        w_nextMf = 2'd0;
        if (w_boundary && i_sync_n) w_nextState = ST_ILA;
      end
      ST_ILA: begin
        if (w_resync) begin
          w_nextState = ST_CGS;
          w_nextMf    = 2'd0;
        end else if (w_boundary) begin
          if (r_ilaMf == 2'd3) begin
            w_nextState = ST_DATA;
            w_nextMf    = 2'd0;
          end else begin
            w_nextMf = r_ilaMf + 2'd1;
          end
        end
      end
      ST_DATA: begin
        w_nextMf = 2'd0;
        if (w_resync) w_nextState = ST_CGS;
      end
      default: begin
        w_nextState = ST_CGS;
        w_nextMf    = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_CGS;
      r_ilaMf   <= 2'd0;
      r_lowRun  <= 8'd0;
      r_mux     <= MUX_K;
      r_syncErr <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_ilaMf   <= w_nextMf;
      r_lowRun  <= w_lowNext;
      r_mux     <= muxOf(w_nextState);
      r_syncErr <= w_errNext;
    end
  end

  assign o_state    = r_state;
  assign o_ila_mf   = r_ilaMf;
  assign o_link_mux = r_mux;
  assign o_sync_err = r_syncErr;

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Scoreboard bench for tx_link_ctrl (F=2, K=16, RESYNC_CYC=19): directed
// SYNC~ vectors push per-cycle expectations that a negedge monitor checks.
module tb_tx_link_ctrl;

  localparam int F  = 2;
  localparam int K  = 16;
  localparam int RC = 19;
  localparam int MF = F * K;

  localparam logic [1:0] CGS  = 2'd0;
  localparam logic [1:0] ILA  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_sync_n = 1'b0;
  logic [2:0] o_link_mux;
  logic [1:0] o_state;
  logic       o_lmfc;
  logic       o_frame_start;
  logic [1:0] o_ila_mf;
  logic       o_sync_err;

  typedef struct {
    int         cyc;
    string      name;
    logic [1:0] st;
    logic [2:0] mux;
    logic       lmfc;
    logic       fs;
    logic [1:0] mf;
    logic       err;
  } exp_t;

  exp_t expQ[$];
  int   tcnt = 0;
  int   nChecks = 0;
  int   nFails = 0;

  tx_link_ctrl #(
    .F(F),
    .K(K),
    .RESYNC_CYC(RC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sync_n     (i_sync_n),
    .o_link_mux   (o_link_mux),
    .o_state      (o_state),
    .o_lmfc       (o_lmfc),
    .o_frame_start(o_frame_start),
    .o_ila_mf     (o_ila_mf),
    .o_sync_err   (o_sync_err)
  );

  always #5 clk = ~clk;

  // Expected outputs for cycle tcnt; LMFC phase counts from the last reset edge.
  task automatic pushExp(input string nm, input logic [1:0] st, input logic [1:0] mf,
                         input logic err);
    exp_t e;
    e.cyc  = tcnt;
    e.name = nm;
    e.st   = st;
    e.mux  = (st == CGS) ? 3'd1 : ((st == ILA) ? 3'd2 : 3'd0);
    e.lmfc = ((tcnt % MF) == 0);
    e.fs   = ((tcnt % F) == 0);
    e.mf   = mf;
    e.err  = err;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input int n, input logic s, input string nm,
                               input logic [1:0] st, input logic [1:0] mf, input logic err);
    repeat (n) begin
      i_sync_n = s;
      @(posedge clk);
      #1;
      tcnt++;
      pushExp(nm, st, mf, err);
    end
  endtask

  task automatic doReset(input int edges);
    rst_n = 1'b0;
    repeat (edges) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    tcnt  = 0;
    pushExp("resetState", CGS, 2'd0, 1'b0);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [9:0] got;
    logic [9:0] want;
    got  = {o_state, o_link_mux, o_lmfc, o_frame_start, o_ila_mf, o_sync_err};
    want = {e.st, e.mux, e.lmfc, e.fs, e.mf, e.err};
    nChecks++;
    if (e.cyc != tcnt) begin
      nFails++;
      $display("[TB] FAIL %s: expectation for cycle %0d reached monitor at cycle %0d",
               e.name, e.cyc, tcnt);
    end else if (got !== want) begin
      nFails++;
      $display("[TB] FAIL %s @cyc %0d: got st=%0d mux=%0d lmfc=%b fs=%b mf=%0d err=%b, want st=%0d mux=%0d lmfc=%b fs=%b mf=%0d err=%b",
               e.name, tcnt, o_state, o_link_mux, o_lmfc, o_frame_start, o_ila_mf,
               o_sync_err, e.st, e.mux, e.lmfc, e.fs, e.mf, e.err);
    end
  endtask

  // Monitor: decoupled from stimulus, drains every expectation due this cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (expQ.size() > 0 && expQ[0].cyc <= tcnt) begin
        checkOutput(expQ.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_sync_n = 1'b0;
    doReset(3);

    // CGS hold with SYNC~ low
    applyStimulus(200, 1'b0, "cgsHold", CGS, 2'd0, 1'b0);

    // SYNC~ rises at LMFC count 10, ILA at the next boundary, then DATA
    applyStimulus(2, 1'b0, "cgsPreSync", CGS, 2'd0, 1'b0);
    applyStimulus(21, 1'b1, "cgsWaitBoundary", CGS, 2'd0, 1'b0);
    applyStimulus(32, 1'b1, "ilaMf0", ILA, 2'd0, 1'b0);
    applyStimulus(32, 1'b1, "ilaMf1", ILA, 2'd1, 1'b0);
    applyStimulus(32, 1'b1, "ilaMf2", ILA, 2'd2, 1'b0);
    applyStimulus(32, 1'b1, "ilaMf3", ILA, 2'd3, 1'b0);
    applyStimulus(9, 1'b1, "dataEntry", DATA, 2'd0, 1'b0);

    // Short low pulse in DATA -> single error pulse
    applyStimulus(5, 1'b0, "dataLowShort", DATA, 2'd0, 1'b0);
    applyStimulus(1, 1'b1, "syncErrPulse", DATA, 2'd0, 1'b1);
    applyStimulus(4, 1'b1, "syncErrClear", DATA, 2'd0, 1'b0);

    // 19-cycle low run in DATA -> resync on the 19th edge
    applyStimulus(18, 1'b0, "dataLowLong", DATA, 2'd0, 1'b0);
    applyStimulus(1, 1'b0, "resyncToCgs", CGS, 2'd0, 1'b0);
    applyStimulus(26, 1'b1, "cgsAfterResync", CGS, 2'd0, 1'b0);
    applyStimulus(1, 1'b1, "reIla", ILA, 2'd0, 1'b0);
    applyStimulus(31, 1'b1, "reIlaMf0", ILA, 2'd0, 1'b0);
    applyStimulus(32, 1'b1, "reIlaMf1", ILA, 2'd1, 1'b0);
    applyStimulus(1, 1'b1, "reIlaMf2", ILA, 2'd2, 1'b0);

    // Reset in the middle of ILA multiframe 2
    i_sync_n = 1'b1;
    doReset(1);

    // Boundary glitch: low only at count 31 delays ILA by one multiframe
    applyStimulus(31, 1'b1, "glitchPre", CGS, 2'd0, 1'b0);
    applyStimulus(1, 1'b0, "glitchBoundary", CGS, 2'd0, 1'b0);
    applyStimulus(31, 1'b1, "glitchRetry", CGS, 2'd0, 1'b0);
    applyStimulus(1, 1'b1, "glitchIla", ILA, 2'd0, 1'b0);

    // Short low pulse inside ILA must not report an error
    applyStimulus(6, 1'b1, "ilaPrePulse", ILA, 2'd0, 1'b0);
    applyStimulus(3, 1'b0, "ilaLowPulse", ILA, 2'd0, 1'b0);
    applyStimulus(1, 1'b1, "ilaNoErr", ILA, 2'd0, 1'b0);
    applyStimulus(21, 1'b1, "ilaMf0b", ILA, 2'd0, 1'b0);
    applyStimulus(32, 1'b1, "ilaMf1b", ILA, 2'd1, 1'b0);
    applyStimulus(32, 1'b1, "ilaMf2b", ILA, 2'd2, 1'b0);
    applyStimulus(14, 1'b1, "ilaMf3b", ILA, 2'd3, 1'b0);

    // Resync lands exactly on the ILA-end boundary and wins
    applyStimulus(18, 1'b0, "ilaLowLong", ILA, 2'd3, 1'b0);
    applyStimulus(1, 1'b0, "resyncPriority", CGS, 2'd0, 1'b0);
    applyStimulus(2, 1'b1, "cgsNoErr", CGS, 2'd0, 1'b0);

    @(negedge clk);
    @(posedge clk);
    #1;
    while (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      nChecks++;
      nFails++;
      $display("[TB] FAIL %s: expectation for cycle %0d never checked, now cycle %0d",
               e.name, e.cyc, tcnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/tx_link_ctrl.md
TX_LINK_CTRL -- requirements
Module: tx_link_ctrl

Interface
REQ-001 SHALL have parameter F, default 2, octets per frame (1..256).
REQ-002 SHALL have parameter K, default 16, frames per multiframe; F*K SHALL be at most 1024.
REQ-003 SHALL have parameter RESYNC_CYC, default 5*F+9, consecutive low i_sync_n cycles that trigger a resync (1..255).
REQ-004 SHALL have port clk  input  1  character clock; one octet per cycle; the only clock.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port i_sync_n  input  1  JESD204B SYNC~ from the receiver; low = synchronisation request.
REQ-007 SHALL have port o_link_mux  output  3  stream select to the link layer: 0 user data, 1 continuous K, 2 ILA.
REQ-008 SHALL have port o_state  output  2  current state: 0 CGS, 1 ILA, 2 DATA.
REQ-009 SHALL have port o_lmfc  output  1  high while the LMFC octet counter is 0.
REQ-010 SHALL have port o_frame_start  output  1  high while the octet-in-frame index is 0.
REQ-011 SHALL have port o_ila_mf  output  2  ILA multiframe index 0..3; 0 outside ILA.
REQ-012 SHALL have port o_sync_err  output  1  one-cycle pulse on an error report, as defined in REQ-021.

Function
REQ-013 SHALL keep a free-running LMFC counter, 0..F*K-1, that wraps to 0; it SHALL also keep an octet-in-frame index, 0..F-1, that wraps.
REQ-014 SHALL keep all outputs registered, and o_link_mux SHALL always be the decode of o_state: CGS->1, ILA->2, DATA->0.
REQ-015 SHALL, in CGS, move to ILA on the clock edge where the LMFC counter equals F*K-1 and i_sync_n is sampled high, so the first ILA octet aligns with o_lmfc=1.
REQ-016 SHALL stay in CGS, and retry at the next boundary, when i_sync_n is low at the boundary cycle, including any low pulse between boundaries.
REQ-017 SHALL, in ILA, increment o_ila_mf at each LMFC wrap; on the edge where o_ila_mf=3 and the counter equals F*K-1, it SHALL enter DATA, giving exactly 4*F*K ILA cycles.
REQ-018 SHALL keep a saturating 8-bit low-run counter of consecutive cycles with i_sync_n=0; it SHALL clear on any cycle with i_sync_n=1.
REQ-019 SHALL, in ILA or DATA, enter CGS on the edge where the low-run counter reaches RESYNC_CYC; it SHALL clear o_ila_mf at the same edge.
REQ-020 SHALL NOT reset the LMFC counter on a state transition; the counter SHALL reset only through rst_n.
REQ-021 SHALL pulse o_sync_err for one cycle when, in DATA, i_sync_n returns high after a low run of 1..RESYNC_CYC-1 cycles; it SHALL NOT pulse in CGS or ILA.
REQ-022 SHALL give the resync rule of REQ-019 priority when a resync and an ILA-end boundary fall on the same edge.
REQ-023 SHALL ignore i_sync_n outside the boundary cycle while in CGS, apart from the low-run counter.

Reset
REQ-024 SHALL, on any edge with rst_n=0 and from any state, set the following: state CGS, o_link_mux=1, LMFC counter 0, frame index 0, o_ila_mf=0, low-run counter 0, o_sync_err=0.
REQ-025 SHALL drive o_lmfc=1 and o_frame_start=1 in the first cycle after reset releases.

Structure
REQ-026 SHALL take the state encoding (CGS/ILA/DATA) and the mux codes (MUX_USER=0, MUX_K=1, MUX_ILA=2) from the shared package tx_link_pkg.
REQ-027 SHALL implement the LMFC counter and frame index as the sub-module lmfc_counter (parameters F, K; outputs count, frame index, o_lmfc, o_frame_start).
REQ-028 SHALL fit in 120-400 lines of RTL, with no clock other than clk.

Verification (F=2, K=16, F*K=32, RESYNC_CYC=19)
REQ-029 SHALL cover reset and CGS hold: i_sync_n held low for 200 cycles after reset -> o_state=0 and o_link_mux=1 throughout; o_lmfc=1 every 32 cycles.
REQ-030 SHALL cover the CGS->ILA->DATA sequence: i_sync_n goes high at LMFC count 10 -> ILA starts when the counter is 0 (22 cycles later); o_ila_mf steps 0,1,2,3 at 32-cycle intervals; DATA (o_link_mux=0) starts after exactly 128 ILA cycles.
REQ-031 SHALL cover the error report: in DATA, i_sync_n low for 5 cycles -> one o_sync_err pulse when it returns high; state stays DATA.
REQ-032 SHALL cover resync: in DATA, i_sync_n low for 19 cycles -> CGS on the 19th edge with o_link_mux=1; no o_sync_err pulse; re-entry into ILA waits for the next boundary after i_sync_n goes high.
REQ-033 SHALL cover a boundary glitch: in CGS, i_sync_n high except low at count 31 -> stays CGS and enters ILA one multiframe later.
REQ-034 SHALL cover reset mid-ILA: rst_n low for 1 cycle at o_ila_mf=2 -> next cycle o_state=0, o_ila_mf=0, o_lmfc=1.
